// File: rtl/sc_fifo_pkg.sv
// Shared constants and width helper for the stream FIFO.
// Used by sc_fifo_stream and sc_fifo_ram.
package sc_fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 12;

    // Bits needed to index/count n values; never below one.
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module sc_fifo_ram
    import sc_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_DEPTH - 1,
    parameter int AW     = cw(WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_rd_en) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/sc_fifo_stream.sv
// First-word-fall-through FIFO: RAM of DEPTH-1 words plus one output stage.
// Optional watermark flags: define SC_FIFO_STREAM_WATERMARK_EN.
module sc_fifo_stream
    import sc_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic [cw(DEPTH+1)-1:0]   level
`ifdef SC_FIFO_STREAM_WATERMARK_EN
    ,
    output logic                     almost_full,
    output logic                     almost_empty
`endif
);

    localparam int LW = cw(DEPTH + 1);
    localparam int RW = DEPTH - 1;
    localparam int AW = cw(RW);
    localparam int CW = cw(DEPTH);

    localparam logic [AW-1:0] A_LAST = AW'(RW - 1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    logic              r_oval;
    logic              r_sel;
    logic              r_ready;
    logic [DATA_W-1:0] r_byp;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_cnt;
    logic [LW-1:0]     r_level;

    logic              w_push;
    logic              w_pop;
    logic              w_ram_empty;
    logic              w_load_byp;
    logic              w_ram_wr;
    logic              w_ram_rd;
    logic [LW-1:0]     w_level_nx;
    logic [DATA_W-1:0] w_ram_q;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == A_LAST) ? '0 : p + A_ONE;
    endfunction

    assign w_push      = s_valid & r_ready;
    assign w_pop       = r_oval & m_ready;
    assign w_ram_empty = (r_cnt == '0);
    // New word bypasses the RAM when the output stage is (or is becoming) empty.
    assign w_load_byp  = w_push & (~r_oval | (w_pop & w_ram_empty));
    assign w_ram_wr    = w_push & ~w_load_byp & ~clear;
    assign w_ram_rd    = w_pop & ~w_ram_empty & ~clear;

    always_comb begin
        w_level_nx = r_level;
        if (clear) begin
            w_level_nx = '0;
        end else if (w_push && !w_pop) begin
            w_level_nx = r_level + L_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nx = r_level - L_ONE;
        end
    end

    sc_fifo_ram #(
        .DATA_W (DATA_W),
        .WORDS  (RW),
        .AW     (AW)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (r_wptr),
        .i_wr_data (s_data),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_oval  <= 1'b0;
            r_sel   <= 1'b0;
            r_ready <= 1'b0;
            r_byp   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_level <= '0;
        end else if (clear) begin
            r_oval  <= 1'b0;
            r_sel   <= 1'b0;
            r_ready <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_level <= '0;
        end else begin
            r_level <= w_level_nx;
            r_ready <= (w_level_nx != L_FULL);
            if (w_load_byp) begin
                r_byp  <= s_data;
                r_sel  <= 1'b0;
                r_oval <= 1'b1;
            end else if (w_ram_rd) begin
                r_sel  <= 1'b1;
                r_oval <= 1'b1;
            end else if (w_pop) begin
                r_oval <= 1'b0;
            end
            if (w_ram_wr) begin
                r_wptr <= nxt(r_wptr);
            end
            if (w_ram_rd) begin
                r_rptr <= nxt(r_rptr);
            end
            case ({w_ram_wr, w_ram_rd})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef SC_FIFO_STREAM_WATERMARK_EN
    logic r_af;
    logic r_ae;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_af <= 1'b0;
            r_ae <= 1'b1;
        end else begin
            r_af <= (w_level_nx >= LW'(AF_LEVEL));
            r_ae <= (w_level_nx <= LW'(AE_LEVEL));
        end
    end

    assign almost_full  = r_af;
    assign almost_empty = r_ae;
`endif

    assign s_ready = r_ready;
    assign m_valid = r_oval;
    assign m_data  = r_sel ? w_ram_q : r_byp;
    assign level   = r_level;

endmodule

// File: tb/tb_sc_fifo_stream.sv
// Bench for sc_fifo_stream: DEPTH=12 and DEPTH=5 instances against a queue model.
// Watermark checks included when SC_FIFO_STREAM_WATERMARK_EN is defined.
module tb_sc_fifo_stream;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        sv0 = 1'b0, mr0 = 1'b0, clr0 = 1'b0;
    logic [31:0] sd0 = '0;
    logic        sr0, mv0;
    logic [31:0] md0;
    logic [3:0]  lvl0;

    logic        sv1 = 1'b0, mr1 = 1'b0, clr1 = 1'b0;
    logic [31:0] sd1 = '0;
    logic        sr1, mv1;
    logic [31:0] md1;
    logic [2:0]  lvl1;

`ifdef SC_FIFO_STREAM_WATERMARK_EN
    logic af0, ae0, af1, ae1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    sc_fifo_stream #(
        .DATA_W(32), .DEPTH(12), .AF_LEVEL(10), .AE_LEVEL(2)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .clear(clr0),
        .s_valid(sv0), .s_data(sd0), .s_ready(sr0),
        .m_valid(mv0), .m_data(md0), .m_ready(mr0),
        .level(lvl0)
`ifdef SC_FIFO_STREAM_WATERMARK_EN
        , .almost_full(af0), .almost_empty(ae0)
`endif
    );

    sc_fifo_stream #(
        .DATA_W(32), .DEPTH(5)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .clear(clr1),
        .s_valid(sv1), .s_data(sd1), .s_ready(sr1),
        .m_valid(mv1), .m_data(md1), .m_ready(mr1),
        .level(lvl1)
`ifdef SC_FIFO_STREAM_WATERMARK_EN
        , .almost_full(af1), .almost_empty(ae1)
`endif
    );

    // Reference model: a circular list of held words per instance.
    logic [31:0] mq [2][16];
    int          mh [2];
    int          mc [2];
    bit          mst[2];

    function automatic int dep(input int i);
        return (i == 0) ? 12 : 5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mstep(input int i, input logic v, input logic [31:0] d,
                         input logic r, input logic c);
        bit push, pop;
        if (c) begin
            mc[i] = 0;
            mh[i] = 0;
        end else begin
            push = v && mst[i] && (mc[i] != dep(i));
            pop  = r && (mc[i] > 0);
            if (pop) begin
                mh[i] = (mh[i] + 1) % 16;
                mc[i]--;
            end
            if (push) begin
                mq[i][(mh[i] + mc[i]) % 16] = d;
                mc[i]++;
            end
        end
        mst[i] = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mc[i] = 0;
                mh[i] = 0;
                mst[i] = 1'b0;
            end
        end else begin
            mstep(0, sv0, sd0, mr0, clr0);
            mstep(1, sv1, sd1, mr1, clr1);
        end
    end

    task automatic cmp(input int i, input logic sr, input logic mv,
                       input logic [31:0] md, input int lv);
        string p;
        p = (i == 0) ? "d12" : "d5";
        chk({p, ".level"}, 32'(lv), 32'(mc[i]));
        chk({p, ".s_ready"}, {31'b0, sr},
            {31'b0, (mst[i] && (mc[i] != dep(i)))});
        chk({p, ".m_valid"}, {31'b0, mv}, {31'b0, (mc[i] > 0)});
        if (mc[i] > 0) begin
            chk({p, ".m_data"}, md, mq[i][mh[i]]);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            cmp(0, sr0, mv0, md0, int'(lvl0));
            cmp(1, sr1, mv1, md1, int'(lvl1));
`ifdef SC_FIFO_STREAM_WATERMARK_EN
            chk("d12.almost_full", {31'b0, af0}, {31'b0, (mc[0] >= 10)});
            chk("d12.almost_empty", {31'b0, ae0}, {31'b0, (mc[0] <= 2)});
            chk("d5.almost_full", {31'b0, af1}, {31'b0, (mc[1] >= 3)});
            chk("d5.almost_empty", {31'b0, ae1}, {31'b0, (mc[1] <= 2)});
`endif
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        sv0 = v;
        sd0 = d;
        mr0 = r;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.s_ready", {31'b0, sr0}, 32'd0);
        chk("rst.m_valid", {31'b0, mv0}, 32'd0);
        chk("rst.m_data", md0, 32'd0);
        chk("rst.level", 32'(lvl0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst.s_ready", {31'b0, sr0}, 32'd1);

        cyc(1'b1, 32'hA5, 1'b0);
        chk("a5.m_valid", {31'b0, mv0}, 32'd1);
        chk("a5.m_data", md0, 32'hA5);
        chk("a5.level", 32'(lvl0), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("a5_pop.level", 32'(lvl0), 32'd0);

        for (int k = 1; k <= 12; k++) begin
            cyc(1'b1, 32'(k), 1'b0);
`ifdef SC_FIFO_STREAM_WATERMARK_EN
            chk("fill.almost_full", {31'b0, af0}, {31'b0, (k >= 10)});
            chk("fill.almost_empty", {31'b0, ae0}, {31'b0, (k <= 2)});
`endif
        end
        chk("full.s_ready", {31'b0, sr0}, 32'd0);
        chk("full.level", 32'(lvl0), 32'd12);
        cyc(1'b1, 32'hD, 1'b0);
        chk("13th.level", 32'(lvl0), 32'd12);
        sv0 = 1'b0;
        mr0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            chk("drain.m_data", md0, 32'(k));
            @(negedge clk);
        end
        chk("drain.m_valid", {31'b0, mv0}, 32'd0);
        chk("drain.level", 32'(lvl0), 32'd0);

        for (int k = 1; k <= 12; k++) cyc(1'b1, 32'h100 + 32'(k), 1'b0);
        cyc(1'b1, 32'h55, 1'b1);
        chk("full_pop.level", 32'(lvl0), 32'd11);
        chk("full_pop.s_ready", {31'b0, sr0}, 32'd1);
        for (int k = 0; k < 11; k++) cyc(1'b0, 32'h0, 1'b1);
        chk("full_pop.empty", 32'(lvl0), 32'd0);

        cyc(1'b1, 32'h11, 1'b0);
        cyc(1'b1, 32'h22, 1'b1);
        chk("l1.m_valid", {31'b0, mv0}, 32'd1);
        chk("l1.m_data", md0, 32'h22);
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 32'h30 + 32'(j), 1'b1);
            chk("thru.m_data", md0, 32'h30 + 32'(j));
            chk("thru.level", 32'(lvl0), 32'd1);
        end
        cyc(1'b0, 32'h0, 1'b1);

        for (int k = 0; k < 7; k++) cyc(1'b1, 32'h200 + 32'(k), 1'b0);
        chk("pre_clr.level", 32'(lvl0), 32'd7);
        clr0 = 1'b1;
        cyc(1'b1, 32'hDEAD, 1'b0);
        clr0 = 1'b0;
        chk("clr.level", 32'(lvl0), 32'd0);
        chk("clr.m_valid", {31'b0, mv0}, 32'd0);
        cyc(1'b1, 32'h77, 1'b0);
        chk("clr.next_word", md0, 32'h77);
        cyc(1'b0, 32'h0, 1'b1);
        mr0 = 1'b0;

        for (int c = 0; c < 1000; c++) begin
            int ph, pv, pr;
            ph = (c / 125) % 3;
            pv = (ph == 0) ? 85 : (ph == 1) ? 30 : 60;
            pr = (ph == 0) ? 30 : (ph == 1) ? 85 : 60;
            sv0  = ($urandom_range(0, 99) < pv);
            mr0  = ($urandom_range(0, 99) < pr);
            sd0  = $urandom;
            clr0 = ($urandom_range(0, 199) == 0);
            sv1  = ($urandom_range(0, 99) < pv);
            mr1  = ($urandom_range(0, 99) < pr);
            sd1  = $urandom;
            clr1 = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        sv1 = 1'b0;
        mr1 = 1'b0;
        clr1 = 1'b0;
        clr0 = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h300 + 32'(k), 1'b0);
        sv0 = 1'b0;

        #2 reset_n = 1'b0;
        #1;
        chk("arst.level", 32'(lvl0), 32'd0);
        chk("arst.m_valid", {31'b0, mv0}, 32'd0);
        chk("arst.m_data", md0, 32'd0);
        chk("arst.s_ready", {31'b0, sr0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
